prescaled_counter_bank: RTL

Multi-channel successor to the team's single prescaled event counter. Each of NUM_CHANNELS independent channels has its own run-time programmable prescaler, a COUNT_WIDTH-bit main counter, direction and wrap/saturate control, and a compare register with a one-cycle match pulse. A simple single-cycle write port configures the bank. It sits beside the timing/event logic and feeds count values and match/wrap pulses to downstream control.

---
 rtl/prescaled_counter_pkg.sv | 19 +
 rtl/prescaled_counter_channel.sv | 106 ++++++++++
 rtl/prescaled_counter_bank.sv | 54 +++++
 3 files changed

// File: rtl/prescaled_counter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prescaled_counter_pkg: shared field addresses and control bits    |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
package prescaled_counter_pkg;

  typedef enum logic [1:0] {
    FIELD_COUNT    = 2'd0,
    FIELD_PRESCALE = 2'd1,
    FIELD_COMPARE  = 2'd2,
    FIELD_CONTROL  = 2'd3
  } field_e;

  localparam int CTL_DIR = 0;
  localparam int CTL_SAT = 1;

endpackage
`default_nettype wire

// File: rtl/prescaled_counter_channel.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prescaled_counter_channel: one prescaled up/down counter channel  |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module prescaled_counter_channel
  import prescaled_counter_pkg::*;
#(
  parameter int COUNT_WIDTH              = 16,
  parameter int PRESCALE_WIDTH           = 8,
  parameter int DEFAULT_CYCLES_PER_COUNT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_write,
  input  logic [1:0]             i_waddr,
  input  logic [COUNT_WIDTH-1:0] i_wdata,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_match,
  output logic                   o_wrap
);

  localparam logic [PRESCALE_WIDTH-1:0] c_DEF_PER  = PRESCALE_WIDTH'(DEFAULT_CYCLES_PER_COUNT - 1);
  localparam logic [PRESCALE_WIDTH-1:0] c_PC_ONE   = PRESCALE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]    c_CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]    c_CNT_ONES = '1;

  logic [PRESCALE_WIDTH-1:0] r_pc;
  logic [PRESCALE_WIDTH-1:0] r_per;
  logic [COUNT_WIDTH-1:0]    r_count;
  logic [COUNT_WIDTH-1:0]    r_cmp;
  logic [1:0]                r_ctl;
  logic                      r_match;
  logic                      r_wrap;

  logic [COUNT_WIDTH-1:0]    w_next;
  logic                      w_wrap;

  // Value the counter takes if this cycle ticks; saturation holds at the rail.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (r_ctl[CTL_DIR]) begin
      if (r_count == '0) begin
        if (!r_ctl[CTL_SAT]) begin
          w_next = c_CNT_ONES;
          w_wrap = 1'b1;
        end
      end else begin
        w_next = r_count - c_CNT_ONE;
      end
    end else begin
      if (r_count == c_CNT_ONES) begin
        if (!r_ctl[CTL_SAT]) begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        w_next = r_count + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_per   <= c_DEF_PER;
      r_count <= '0;
      r_cmp   <= '1;
      r_ctl   <= 2'b00;
      r_match <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_wrap  <= 1'b0;
      if (i_write) begin
        case (field_e'(i_waddr))
          FIELD_COUNT:    r_count <= i_wdata;
          FIELD_PRESCALE: begin
            r_per <= i_wdata[PRESCALE_WIDTH-1:0];
            r_pc  <= '0;
          end
          FIELD_COMPARE:  r_cmp <= i_wdata;
          FIELD_CONTROL:  r_ctl <= i_wdata[1:0];
          default:        r_ctl <= r_ctl;
        endcase
      end else if (i_enable) begin
        if (r_pc == r_per) begin
          r_pc    <= '0;
          r_count <= w_next;
          r_match <= (w_next == r_cmp);
          r_wrap  <= w_wrap;
        end else begin
          r_pc <= r_pc + c_PC_ONE;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_match = r_match;
  assign o_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: rtl/prescaled_counter_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prescaled_counter_bank: bank of independent prescaled counters    |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module prescaled_counter_bank
  import prescaled_counter_pkg::*;
#(
  parameter int NUM_CHANNELS             = 4,
  parameter int COUNT_WIDTH              = 16,
  parameter int PRESCALE_WIDTH           = 8,
  parameter int DEFAULT_CYCLES_PER_COUNT = 8
) (
  input  logic                                                 clock_i,
  input  logic                                                 reset_i,
  input  logic [NUM_CHANNELS-1:0]                              enable_i,
  input  logic                                                 write_i,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] wsel_i,
  input  logic [1:0]                                           waddr_i,
  input  logic [COUNT_WIDTH-1:0]                               wdata_i,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]                  count_o,
  output logic [NUM_CHANNELS-1:0]                              match_o,
  output logic [NUM_CHANNELS-1:0]                              wrap_o
);

  localparam int c_SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] w_wr;

  // Selects with no matching channel (>= NUM_CHANNELS) simply decode to no strobe.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    localparam logic [c_SEL_W-1:0] c_SEL = c_SEL_W'(c);

    assign w_wr[c] = write_i && (wsel_i == c_SEL);

    prescaled_counter_channel #(
      .COUNT_WIDTH              (COUNT_WIDTH),
      .PRESCALE_WIDTH           (PRESCALE_WIDTH),
      .DEFAULT_CYCLES_PER_COUNT (DEFAULT_CYCLES_PER_COUNT)
    ) u_chan (
      .clk      (clock_i),
      .rst      (reset_i),
      .i_enable (enable_i[c]),
      .i_write  (w_wr[c]),
      .i_waddr  (waddr_i),
      .i_wdata  (wdata_i),
      .o_count  (count_o[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .o_match  (match_o[c]),
      .o_wrap   (wrap_o[c])
    );
  end

endmodule
`default_nettype wire
